// File: rtl/adder_pkg.sv
// Shared constants for the serial adder and its bench.
//   state_t       : FSM encoding (IDLE=0, RUN=1)
//   DEFAULT_WIDTH : default operand/sum width in bits
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// Single-bit full adder made of two half adders and an OR of their carries.
//   a, b : addend bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    // The two half-adder carries can never both be set, so OR is exact.
    assign cout = c0 | c1;

endmodule : full_adder

// File: rtl/half_adder.sv
// Single-bit half adder.
//   a, b : addend bits
//   s    : sum bit
//   c    : carry bit
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : half_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, LSB first, one bit per clock.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request an addition (ignored while busy)
//   a, b  : operands, captured when start is accepted
//   cin   : carry in, captured when start is accepted
//   busy  : high while an addition is running
//   done  : one-cycle pulse, sum/cout just updated
//   sum   : result of the last completed addition
//   cout  : carry out of the last completed addition
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                // Sum bits enter at the MSB so that after WIDTH shifts
                // bit 0 of the result has reached bit 0 of the register.
                s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
                carry_d = fa_cout;
                if (cnt_q == LAST_BIT) begin
                    // Counter parks on the last bit instead of wrapping.
                    sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and random bench for serial_adder (WIDTH=8) with a result scoreboard.
module tb_serial_adder;
    import adder_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   sb[$];
    logic [W:0]   prev_res = '0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .cin   (cin_i),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; optionally record the reference result.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input bit push);
        start = 1'b1;
        a_i   = a;
        b_i   = b;
        cin_i = c;
        tick();
        start = 1'b0;
        if (push) sb.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    endtask

    // Wait for done (bounded), checking busy and output hold on the way,
    // then check latency and the scoreboard result.
    task automatic wait_done(input string tag, input int exp_lat);
        int         lat  = 0;
        bit         seen = 0;
        logic [W:0] exp;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (done) begin
                seen = 1;
                break;
            end
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_hold"}, 64'({cout, sum}), 64'(prev_res));
        end
        chk({tag, "_latency"}, 64'(seen ? lat : 0), 64'(exp_lat));
        if (seen) begin
            chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL %s_scoreboard observed=done expected=no_pending_op", tag);
            end else begin
                exp = sb.pop_front();
                chk({tag, "_result"}, 64'({cout, sum}), 64'(exp));
                prev_res = exp;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        a_i   = 8'hFF;
        b_i   = 8'hFF;
        cin_i = 1'b1;
        tick();
        tick();
        // start held high under reset must be discarded
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // Basic addition
        drive_start(8'h37, 8'h29, 1'b0, 1);
        chk("basic_busy_accept", 64'(busy), 64'd1);
        wait_done("basic", W);
        chk("basic_sum", 64'(sum), 64'h60);
        tick();
        chk("basic_done_pulse", 64'(done), 64'd0);

        // Overflow cases
        drive_start(8'hFF, 8'h01, 1'b0, 1);
        wait_done("ovf1", W);
        tick();
        drive_start(8'hA5, 8'h5A, 1'b1, 1);
        wait_done("ovf2", W);
        chk("ovf2_sumcout", 64'({cout, sum}), 64'h100);
        tick();

        // start during RUN is ignored
        drive_start(8'h37, 8'h29, 1'b0, 1);
        tick();
        tick();
        start = 1'b1;
        a_i   = 8'h11;
        b_i   = 8'h22;
        tick();
        start = 1'b0;
        wait_done("ignore", W - 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ignore_no_done", 64'(done), 64'd0);
            chk("ignore_idle", 64'(busy), 64'd0);
        end
        chk("ignore_sum", 64'({cout, sum}), 64'h060);

        // Reset abort in the middle of RUN
        drive_start(8'hFF, 8'h01, 1'b0, 1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        prev_res = '0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'd0);
        end

        // Back-to-back: second start accepted in the done cycle
        drive_start(8'h37, 8'h29, 1'b0, 1);
        wait_done("b2b_first", W);
        drive_start(8'h01, 8'h01, 1'b0, 1);
        chk("b2b_hold_accept", 64'(sum), 64'h60);
        wait_done("b2b_second", W);
        chk("b2b_sum", 64'({cout, sum}), 64'h002);

        // Random back-to-back stream
        for (int n = 0; n < 1000; n++) begin
            drive_start(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), 1);
            wait_done("rand", W);
        end
        tick();
        chk("final_done_low", 64'(done), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder
